// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Instruction-fetch responder sitting between the PC block, instruction
// memory and decode. It samples the PC's current value, runs a req/ack read
// to memory and hands (inst, pc) pairs to decode over valid/ready. A single
// entry skid buffer holds a returned word when decode is back-pressuring.
// pc_stall tells the PC block whether it may advance by 4 at the next edge.
//
// Optional feature (macro INST_FETCH_TIMEOUT_EN): an ack watchdog that
// abandons a request after TIMEOUT_CYC waiting cycles, pulses fetch_fault and
// re-fetches from the current pc. Without the macro the block waits for
// mem_ack indefinitely and has no fetch_fault port.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   pc           current PC value
//   branch_flag  redirect/flush (PC loads the target on the same edge)
//   mem_req      read request, held high until mem_ack
//   mem_addr     read address, stable while mem_req is high
//   mem_ack      one-cycle response strobe; mem_rdata valid with it
//   mem_rdata    instruction word
//   id_valid     id_inst/id_pc valid toward decode
//   id_ready     decode accepts when id_valid & id_ready
//   id_inst      fetched instruction (NOP_INST after reset/flush)
//   id_pc        address of id_inst
//   pc_stall     combinational; 0 lets the PC advance by 4
//   fetch_fault  (optional) one-cycle pulse on watchdog expiry
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
`ifdef INST_FETCH_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYC = 15
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch_flag,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic              pc_stall
`ifdef INST_FETCH_TIMEOUT_EN
    ,
    output logic              fetch_fault
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, SKID, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_d, id_pc_d, skid_addr, skid_addr_d;
    logic [31:0]       id_inst_d, skid_inst, skid_inst_d;
    logic              id_valid_d;
    logic              slot_free;

`ifdef INST_FETCH_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
    logic             fault_d;
`endif

    // Request is a pure function of state so an asynchronous reset drops it
    // immediately, even in the middle of an outstanding read.
    assign mem_req   = (state == REQ) || (state == DRAIN);
    assign slot_free = !id_valid || id_ready;

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state;
        addr_d      = mem_addr;
        id_valid_d  = id_valid & ~id_ready;  // decode consumption
        id_inst_d   = id_inst;
        id_pc_d     = id_pc;
        skid_inst_d = skid_inst;
        skid_addr_d = skid_addr;
        pc_stall    = 1'b1;
`ifdef INST_FETCH_TIMEOUT_EN
        wait_cnt_d  = '0;
        fault_d     = 1'b0;
`endif

        if (branch_flag) begin
            // Redirect wins over everything. An outstanding read without its
            // ack must still be completed, so it is drained and discarded.
            id_valid_d  = 1'b0;
            id_inst_d   = NOP_INST;
            skid_inst_d = '0;
            skid_addr_d = '0;
            case (state)
                REQ, DRAIN: state_d = mem_ack ? IDLE : DRAIN;
                default:    state_d = IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    addr_d  = pc;
                    state_d = REQ;
                end
                REQ: begin
                    if (mem_ack) begin
                        if (slot_free) begin
                            id_valid_d = 1'b1;
                            id_inst_d  = mem_rdata;
                            id_pc_d    = mem_addr;
                            addr_d     = mem_addr + STEP;
                            pc_stall   = 1'b0;
                        end else begin
                            // Output slot busy: park the word, stop requesting.
                            skid_inst_d = mem_rdata;
                            skid_addr_d = mem_addr;
                            state_d     = SKID;
                        end
                    end
                end
                SKID: begin
                    if (id_ready) begin
                        id_valid_d = 1'b1;
                        id_inst_d  = skid_inst;
                        id_pc_d    = skid_addr;
                        addr_d     = skid_addr + STEP;
                        pc_stall   = 1'b0;
                        state_d    = REQ;
                    end
                end
                DRAIN: begin
                    if (mem_ack) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef INST_FETCH_TIMEOUT_EN
        // Watchdog counts consecutive ack-less cycles in one waiting state.
        if (mem_req && !mem_ack && (state_d == state)) begin
            if (wait_cnt == CNT_LAST) begin
                state_d = IDLE;
                fault_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt + 1'b1;
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // NOTE: the skid entry is a plain register, not a memory array, so it is
    // reset along with the rest of the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            id_valid  <= 1'b0;
            id_inst   <= NOP_INST;
            id_pc     <= '0;
            skid_inst <= '0;
            skid_addr <= '0;
        end else begin
            mem_addr  <= addr_d;
            id_valid  <= id_valid_d;
            id_inst   <= id_inst_d;
            id_pc     <= id_pc_d;
            skid_inst <= skid_inst_d;
            skid_addr <= skid_addr_d;
        end
    end

`ifdef INST_FETCH_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            fetch_fault <= 1'b0;
        end else begin
            wait_cnt    <= wait_cnt_d;
            fetch_fault <= fault_d;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//
// Self-checking bench for inst_fetch (ADDR_W=32). Directed cycle tables cover
// start-up, back-pressure, both flush flavours and address wrap; a random
// phase drives a memory with variable latency, random decode back-pressure
// and random redirects, and checks the delivered instruction stream against
// a simple "sequential from the last redirect" model.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        branch_flag = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        id_ready = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        pc_stall;
`ifdef INST_FETCH_TIMEOUT_EN
    logic        fetch_fault;
`endif

    int total = 0;
    int bad   = 0;

    inst_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .branch_flag (branch_flag),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .pc_stall    (pc_stall)
`ifdef INST_FETCH_TIMEOUT_EN
        ,
        .fetch_fault (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        logic        ack;
        logic        rdy;
        logic [31:0] pc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_idpc;
        logic        e_stall;
        logic        e_nop;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic br, input logic ack, input logic rdy,
                                input logic [31:0] p, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_idpc, input logic e_stall,
                                input logic e_nop);
        vec_t v;
        v.br = br; v.ack = ack; v.rdy = rdy; v.pc = p;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_idpc = e_idpc; v.e_stall = e_stall; v.e_nop = e_nop;
        return v;
    endfunction

    // Called at a negedge: drive one cycle of inputs, check, advance.
    task automatic apply_vec(input vec_t v, input string tag);
        branch_flag = v.br;
        mem_ack     = v.ack;
        id_ready    = v.rdy;
        pc          = v.pc;
        mem_rdata   = v.e_addr ^ KEY;
        #1;
        check({tag, ".mem_req"},  32'(mem_req),  32'(v.e_req));
        check({tag, ".mem_addr"}, mem_addr,      v.e_addr);
        check({tag, ".id_valid"}, 32'(id_valid), 32'(v.e_valid));
        check({tag, ".pc_stall"}, 32'(pc_stall), 32'(v.e_stall));
        if (v.e_valid) begin
            check({tag, ".id_pc"},   id_pc,   v.e_idpc);
            check({tag, ".id_inst"}, id_inst, v.e_idpc ^ KEY);
        end
        if (v.e_nop) check({tag, ".nop"}, id_inst, NOP);
        @(negedge clk);
    endtask

    // Assert reset, optionally check that mem_req drops without a clock edge,
    // then check reset values and release reset at a negedge.
    task automatic do_reset(input logic [31:0] start_pc, input logic chk_drop);
        rst = 1'b1;
        branch_flag = 1'b0; mem_ack = 1'b0; id_ready = 1'b0;
        #1;
        if (chk_drop) check("rst_async_req_drop", 32'(mem_req), 32'h0);
        @(negedge clk);
        check("rst_mem_req",  32'(mem_req),  32'h0);
        check("rst_mem_addr", mem_addr,      32'h0);
        check("rst_id_valid", 32'(id_valid), 32'h0);
        check("rst_id_inst",  id_inst,       NOP);
        check("rst_id_pc",    id_pc,         32'h0);
        rst = 1'b0;
        pc  = start_pc;
    endtask

    task automatic run_random(input int cycles);
        logic [31:0] pc_m, exp_pc, tgt, prev_addr, s_addr, s_idpc, s_inst;
        logic        prev_req, prev_ack, s_req, s_valid, s_stall, s_rdy, s_br, s_ack;
        int          wait_left, hs;
        pc_m = $urandom() & 32'h000F_FFFC;
        do_reset(pc_m, 1'b1);
        exp_pc = pc_m;
        wait_left = 0; hs = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
        for (int i = 0; i < cycles; i++) begin
            pc = pc_m;
            s_br = ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
            branch_flag = s_br;
            id_ready = ($urandom_range(0, 3) != 0);
            if (mem_req) begin
                mem_ack   = (wait_left == 0);
                mem_rdata = mem_addr ^ KEY;
            end else begin
                mem_ack   = ($urandom_range(0, 7) == 0);   // stray ack, must be ignored
                mem_rdata = $urandom();
            end
            #1;
            s_req = mem_req; s_addr = mem_addr; s_valid = id_valid; s_idpc = id_pc;
            s_inst = id_inst; s_stall = pc_stall; s_rdy = id_ready; s_ack = mem_ack;
            if (prev_req && !prev_ack) begin
                check("rnd_req_held",  32'(s_req), 32'h1);
                check("rnd_addr_held", s_addr,     prev_addr);
            end
            if (s_br) check("rnd_flush_stall", 32'(s_stall), 32'h1);
            @(posedge clk);
            if (s_valid && s_rdy) begin
                check("rnd_id_pc",   s_idpc, exp_pc);
                check("rnd_id_inst", s_inst, s_idpc ^ KEY);
                exp_pc = exp_pc + 32'd4;
                hs++;
            end
            if (s_br) begin
                pc_m = tgt;
                exp_pc = tgt;
            end else if (!s_stall) begin
                pc_m = pc_m + 32'd4;
            end
            if (s_req) wait_left = s_ack ? $urandom_range(0, 2) : wait_left - 1;
            prev_req = s_req; prev_ack = s_ack; prev_addr = s_addr;
            @(negedge clk);
        end
        check("rnd_liveness", 32'(hs >= 300), 32'h1);
    endtask

    initial begin
        // Start-up stream, back-pressure into the skid and release.
        //            br ack rdy pc        req addr   val idpc  stall nop
        vecs[0] = mk(0, 1, 1, 32'd0,   0, 32'd0,  0, 32'd0,  1, 1); // IDLE, stray ack
        vecs[1] = mk(0, 1, 1, 32'd0,   1, 32'd0,  0, 32'd0,  0, 0);
        vecs[2] = mk(0, 1, 1, 32'd4,   1, 32'd4,  1, 32'd0,  0, 0);
        vecs[3] = mk(0, 1, 0, 32'd8,   1, 32'd8,  1, 32'd4,  1, 0); // ack while busy
        vecs[4] = mk(0, 1, 0, 32'd8,   0, 32'd8,  1, 32'd4,  1, 0); // SKID, stray ack
        vecs[5] = mk(0, 0, 1, 32'd8,   0, 32'd8,  1, 32'd4,  0, 0); // release
        vecs[6] = mk(0, 1, 1, 32'd12,  1, 32'd12, 1, 32'd8,  0, 0);
        vecs[7] = mk(0, 0, 1, 32'd16,  1, 32'd16, 1, 32'd12, 1, 0);
        vecs[8] = mk(0, 0, 1, 32'd16,  1, 32'd16, 0, 32'd0,  1, 0);

        do_reset(32'd0, 1'b0);
        for (int i = 0; i < 9; i++) apply_vec(vecs[i], $sformatf("basic[%0d]", i));

        // Flush together with an ack at address 4.
        do_reset(32'd0, 1'b1);
        apply_vec(mk(0, 0, 1, 32'd0,         0, 32'd0,         0, 32'd0,  1, 1), "fa0");
        apply_vec(mk(0, 1, 1, 32'd0,         1, 32'd0,         0, 32'd0,  0, 0), "fa1");
        apply_vec(mk(1, 1, 1, 32'd4,         1, 32'd4,         1, 32'd0,  1, 0), "fa2");
        apply_vec(mk(0, 0, 1, 32'h1111_1111, 0, 32'd4,         0, 32'd0,  1, 1), "fa3");
        apply_vec(mk(0, 1, 1, 32'h1111_1111, 1, 32'h1111_1111, 0, 32'd0,  0, 1), "fa4");
        apply_vec(mk(0, 0, 1, 32'h1111_1115, 1, 32'h1111_1115, 1, 32'h1111_1111, 1, 0), "fa5");

        // Flush while waiting; ack arrives three cycles later and is dropped.
        do_reset(32'h100, 1'b1);
        apply_vec(mk(0, 0, 1, 32'h100, 0, 32'h0,   0, 32'h0,   1, 1), "fw0");
        apply_vec(mk(1, 0, 1, 32'h100, 1, 32'h100, 0, 32'h0,   1, 1), "fw1");
        apply_vec(mk(0, 0, 1, 32'h200, 1, 32'h100, 0, 32'h0,   1, 1), "fw2");
        apply_vec(mk(0, 0, 1, 32'h200, 1, 32'h100, 0, 32'h0,   1, 1), "fw3");
        apply_vec(mk(0, 1, 1, 32'h200, 1, 32'h100, 0, 32'h0,   1, 1), "fw4");
        apply_vec(mk(0, 0, 1, 32'h200, 0, 32'h100, 0, 32'h0,   1, 1), "fw5");
        apply_vec(mk(0, 1, 1, 32'h200, 1, 32'h200, 0, 32'h0,   0, 1), "fw6");
        apply_vec(mk(0, 0, 1, 32'h204, 1, 32'h204, 1, 32'h200, 1, 0), "fw7");

        // Address wrap.
        do_reset(32'hFFFF_FFFC, 1'b1);
        apply_vec(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'h0,         1, 1), "wr0");
        apply_vec(mk(0, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0,         0, 0), "wr1");
        apply_vec(mk(0, 0, 1, 32'h0,         1, 32'h0,         1, 32'hFFFF_FFFC, 1, 0), "wr2");

`ifdef INST_FETCH_TIMEOUT_EN
        // Watchdog: 15 ack-less cycles in REQ, then a one-cycle fault pulse.
        do_reset(32'h40, 1'b1);
        id_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            check($sformatf("to_req[%0d]", c),   32'(mem_req),     32'(c > 0));
            check($sformatf("to_fault[%0d]", c), 32'(fetch_fault), 32'h0);
            @(negedge clk);
        end
        pc = 32'h80;
        #1;
        check("to_fault_pulse", 32'(fetch_fault), 32'h1);
        check("to_req_low",     32'(mem_req),     32'h0);
        @(negedge clk);
        #1;
        check("to_fault_clear", 32'(fetch_fault), 32'h0);
        check("to_rereq",       32'(mem_req),     32'h1);
        check("to_rereq_addr",  mem_addr,         32'h80);
        @(negedge clk);
`endif

        run_random(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
